// File: rtl/junction_controller.sv
// Timed phase sequencer for a two-road junction with one pedestrian crossing.
// Main road rests on green; side and pedestrian demands are latched and served in turn.
module junction_controller #(
    parameter int TW           = 8,
    parameter int T_MIN_GREEN  = 8,
    parameter int T_SIDE_GREEN = 6,
    parameter int T_AMBER      = 3,
    parameter int T_RED_AMBER  = 2,
    parameter int T_ALLRED     = 2,
    parameter int T_WALK       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       ped_wait
);

    localparam logic [2:0] RED       = 3'b100;
    localparam logic [2:0] RED_AMBER = 3'b110;
    localparam logic [2:0] GREEN     = 3'b001;
    localparam logic [2:0] AMBER     = 3'b010;

    function automatic bit dwell_ok(int t);
        return (t >= 1) && (t <= (2**TW) - 1);
    endfunction

    localparam bit TIMING_OK = dwell_ok(T_MIN_GREEN) && dwell_ok(T_SIDE_GREEN) &&
                               dwell_ok(T_AMBER) && dwell_ok(T_RED_AMBER) &&
                               dwell_ok(T_ALLRED) && dwell_ok(T_WALK);

    generate
        if (!TIMING_OK) begin : g_bad_timing
            $fatal(1, "junction_controller: every T_* must lie in 1 .. 2**TW-1");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_AR2  = 4'd0,
        S_MRA  = 4'd1,
        S_MG   = 4'd2,
        S_MA   = 4'd3,
        S_AR1  = 4'd4,
        S_WALK = 4'd5,
        S_CLR  = 4'd6,
        S_SRA  = 4'd7,
        S_SG   = 4'd8,
        S_SA   = 4'd9
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          side_pend, ped_pend;
    logic          expired;
    logic          side_clr, ped_clr;

    // Timer load value is dwell-1 so the state lasts exactly its dwell.
    function automatic logic [TW-1:0] dwell(state_t s);
        logic [TW-1:0] d;
        case (s)
            S_MRA, S_SRA: d = TW'(T_RED_AMBER - 1);
            S_MG:         d = TW'(T_MIN_GREEN - 1);
            S_MA, S_SA:   d = TW'(T_AMBER - 1);
            S_WALK:       d = TW'(T_WALK - 1);
            S_SG:         d = TW'(T_SIDE_GREEN - 1);
            default:      d = TW'(T_ALLRED - 1);
        endcase
        return d;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_AR2;
            timer     <= dwell(S_AR2);
            side_pend <= 1'b0;
            ped_pend  <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            side_pend <= side_req | (side_pend & ~side_clr);
            ped_pend  <= ped_req | (ped_pend & ~ped_clr);
        end
    end

    assign expired = (timer == '0);

    always_comb begin
        state_nx = state;
        case (state)
            S_AR2:  if (expired) state_nx = S_MRA;
            S_MRA:  if (expired) state_nx = S_MG;
            S_MG:   if (expired && (side_pend || ped_pend)) state_nx = S_MA;
            S_MA:   if (expired) state_nx = S_AR1;
            S_AR1:  if (expired) state_nx = ped_pend ? S_WALK : S_SRA;
            S_WALK: if (expired) state_nx = S_CLR;
            S_CLR:  if (expired) state_nx = side_pend ? S_SRA : S_MRA;
            S_SRA:  if (expired) state_nx = S_SG;
            S_SG:   if (expired) state_nx = S_SA;
            S_SA:   if (expired) state_nx = S_AR2;
            default: state_nx = S_AR2;
        endcase
    end

    // Reload on every state change; MG saturates at zero while it waits for demand.
    always_comb begin
        timer_nx = timer;
        if (state_nx != state)
            timer_nx = dwell(state_nx);
        else if (!expired)
            timer_nx = timer - 1'b1;
    end

    assign side_clr = (state_nx == S_SG) && (state != S_SG);
    assign ped_clr  = (state_nx == S_WALK) && (state != S_WALK);

    always_comb begin
        main_light = RED;
        side_light = RED;
        walk       = 1'b0;
        case (state)
            S_MRA:  main_light = RED_AMBER;
            S_MG:   main_light = GREEN;
            S_MA:   main_light = AMBER;
            S_WALK: walk       = 1'b1;
            S_SRA:  side_light = RED_AMBER;
            S_SG:   side_light = GREEN;
            S_SA:   side_light = AMBER;
            default: ;
        endcase
    end

    assign ped_wait = ped_pend;

endmodule
